// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions used by the multiply sequencer and its bus interface.
//   alu_op_t : control codes understood by the shared 16-bit adder
//   state_t  : multiply sequencer state encoding
//   N_BITS   : operand width and iteration count (only 16 is supported, matching the adder)
package alu_pkg;

    localparam int N_BITS = 16;
    localparam int CNT_W  = $clog2(N_BITS);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDU = 3'b001,
        OP_SUB  = 3'b010,
        OP_SUBU = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_IDLE = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: request/result bus between the instruction decoder and the multiply sequencer.
//   start   : request a multiply (decoder -> sequencer)
//   mcand   : multiplicand (decoder -> sequencer)
//   mplier  : multiplier (decoder -> sequencer)
//   busy    : sequencer running or finishing (sequencer -> decoder)
//   done    : one-cycle pulse, product valid (sequencer -> decoder)
//   product : 32-bit result, held until the next accepted start (sequencer -> decoder)
interface mul_seq_ctrl_if;
    import alu_pkg::*;

    logic                  start;
    logic [N_BITS-1:0]     mcand;
    logic [N_BITS-1:0]     mplier;
    logic                  busy;
    logic                  done;
    logic [2*N_BITS-1:0]   product;

    modport master (output start, mcand, mplier, input busy, done, product);
    modport slave  (input start, mcand, mplier, output busy, done, product);

endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 16x16 unsigned shift-and-add multiplier sequencer driving an external shared adder.
//   clk, rst     : clock (rising edge) and synchronous active-high reset
//   req          : decoder bus (start/mcand/mplier in, busy/done/product out)
//   add_A, add_B : adder operands (hi and captured multiplicand while running, else 0)
//   add_control  : adder op code (OP_ADDU while running, else OP_IDLE)
//   add_Carryout : adder carry-flag disable (0 while running, else 1)
//   add_C        : adder sum
//   add_coutFlag : adder carry out
module mul_seq_ctrl
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mul_seq_ctrl_if.slave       req,
    output logic [N_BITS-1:0]   add_A,
    output logic [N_BITS-1:0]   add_B,
    output logic [2:0]          add_control,
    output logic                add_Carryout,
    input  logic [N_BITS-1:0]   add_C,
    input  logic                add_coutFlag
);

    state_t                state, state_nxt;
    logic [N_BITS-1:0]     hi, lo, m;
    logic [CNT_W-1:0]      cnt;
    logic [2*N_BITS-1:0]   product_q;
    logic [2*N_BITS-1:0]   acc_nxt;
    logic                  run;

    assign run = (state == S_RUN);

    always_comb begin
        state_nxt = state;
        // The 17-bit partial sum {cout, C} shifts down into the 32-bit accumulator, so nothing is lost.
        acc_nxt   = lo[0] ? {add_coutFlag, add_C, lo[N_BITS-1:1]} : {1'b0, hi, lo[N_BITS-1:1]};
        case (state)
            S_IDLE:  state_nxt = req.start ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = (cnt == CNT_W'(N_BITS - 1)) ? S_DONE : S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        add_A        = run ? hi : '0;
        add_B        = run ? m : '0;
        add_control  = run ? OP_ADDU : OP_IDLE;
        add_Carryout = !run;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hi        <= '0;
            lo        <= '0;
            m         <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req.start) begin
                m   <= req.mcand;
                hi  <= '0;
                lo  <= req.mplier;
                cnt <= '0;
            end else if (run) begin
                {hi, lo} <= acc_nxt;
                cnt      <= cnt + CNT_W'(1);
                if (state_nxt == S_DONE)
                    product_q <= acc_nxt;
            end
        end
    end

    assign req.busy    = (state == S_RUN) || (state == S_DONE);
    assign req.done    = (state == S_DONE);
    assign req.product = product_q;

endmodule
